// File: rtl/acc_pkg.sv
// Shared definitions for the SHA-256 accelerator slave and its fabric-side host master:
// register map, command/status codes and host FSM state encoding.
package acc_pkg;

  localparam logic [4:0]  ACC_ADDR_CTRL   = 5'd16;
  localparam logic [4:0]  ACC_ADDR_STATUS = 5'd17;

  localparam logic [31:0] CMD_START  = 32'hFFFF_FFFF;
  localparam logic [31:0] CMD_ACK    = 32'h0F0F_0F0F;
  localparam logic [31:0] CMD_SRESET = 32'hFF00_00FF;
  localparam logic [31:0] STAT_DONE  = 32'h1111_1111;
  localparam logic [31:0] STAT_BUSY  = 32'h0F0F_F0F0;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_LOAD  = 4'd1;
  localparam logic [3:0] ST_START = 4'd2;
  localparam logic [3:0] ST_WAIT  = 4'd3;
  localparam logic [3:0] ST_POLL  = 4'd4;
  localparam logic [3:0] ST_READ  = 4'd5;
  localparam logic [3:0] ST_ACK   = 4'd6;
  localparam logic [3:0] ST_ABORT = 4'd7;
  localparam logic [3:0] ST_DRAIN = 4'd8;
  localparam logic [3:0] ST_RESP  = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_POLL  = ST_POLL,
    S_READ  = ST_READ,
    S_ACK   = ST_ACK,
    S_ABORT = ST_ABORT,
    S_DRAIN = ST_DRAIN,
    S_RESP  = ST_RESP
  } acc_host_state_e;

endpackage

// File: rtl/acc_host_master_if.sv
// Request/response handshakes and the Avalon-MM initiator bus of acc_host_master.
// Both handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface acc_host_master_if;
  logic         req_valid;
  logic         req_ready;
  logic [511:0] req_block;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_hash;
  logic         rsp_timeout;
  logic         av_chipselect;
  logic         av_write;
  logic         av_read;
  logic [4:0]   av_address;
  logic [31:0]  av_writedata;
  logic [31:0]  av_readdata;

  modport master (
    input  req_valid, req_block, rsp_ready, av_readdata,
    output req_ready, rsp_valid, rsp_hash, rsp_timeout,
           av_chipselect, av_write, av_read, av_address, av_writedata
  );

  modport slave (
    output req_valid, req_block, rsp_ready, av_readdata,
    input  req_ready, rsp_valid, rsp_hash, rsp_timeout,
           av_chipselect, av_write, av_read, av_address, av_writedata
  );
endinterface

// File: rtl/acc_rd_capture.sv
// Tracks hash-word reads through the slave's read latency and stores each returned
// word in the hash slot named by the address it was issued with.
module acc_rd_capture #(
  parameter int READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         issue,
  input  logic [2:0]   idx,
  input  logic [31:0]  rdata,
  input  logic         clr,
  output logic [255:0] hash
);

  logic [READ_LATENCY-1:0] vld;
  logic [2:0]              tag [READ_LATENCY];
  logic [7:0][31:0]        hash_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld    <= '0;
      hash_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag[i] <= '0;
    end else begin
      vld[0] <= issue;
      tag[0] <= idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
      if (clr)
        hash_q <= '0;
      else if (vld[READ_LATENCY-1])
        hash_q[tag[READ_LATENCY-1]] <= rdata;
    end
  end

  assign hash = hash_q;

endmodule

// File: rtl/acc_host_master.sv
// Avalon-MM initiator driving one SHA-256 accelerator slave: load block, start, poll,
// read hash, acknowledge, and return the hash (or a timeout) on the response port.
module acc_host_master
  import acc_pkg::*;
#(
  parameter int READ_LATENCY  = 1,
  parameter int POLL_INTERVAL = 4,
  parameter int POLL_TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  acc_host_master_if.master bus,
  output acc_host_state_e   state_dbg
);

  localparam int              PW        = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PW-1:0]   POLL_MAX  = PW'(POLL_TIMEOUT);
  localparam logic [15:0]     WAIT_LAST = 16'(POLL_INTERVAL - 1);
  localparam logic [15:0]     POLL_LAST = 16'(READ_LATENCY);
  localparam logic [15:0]     READ_LAST = 16'(READ_LATENCY + 7);

  logic [3:0]        state, state_n;
  logic [15:0]       cnt, cnt_n;
  logic [PW-1:0]     poll_cnt, poll_n, poll_inc;
  logic [15:0][31:0] blk_q;
  logic              wr_q, rd_q, cs_q, wr_n, rd_n;
  logic [4:0]        addr_q, addr_n;
  logic [31:0]       data_q, data_n;
  logic              rsp_valid_q, rsp_valid_n, rsp_to_q, rsp_to_n;
  logic              latch, hash_clr, rd_issue;
  logic [255:0]      hash;

  assign poll_inc = (poll_cnt == POLL_MAX) ? poll_cnt : poll_cnt + 1'b1;

  // Bus strobes/address/data are computed for the next cycle so they leave as flops.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    poll_n      = poll_cnt;
    wr_n        = 1'b0;
    rd_n        = 1'b0;
    addr_n      = '0;
    data_n      = '0;
    rsp_valid_n = rsp_valid_q;
    rsp_to_n    = rsp_to_q;
    latch       = 1'b0;
    hash_clr    = 1'b0;
    case (state)
      ST_IDLE: if (bus.req_valid) begin
        state_n  = ST_LOAD;
        latch    = 1'b1;
        wr_n     = 1'b1;
        data_n   = bus.req_block[31:0];
        cnt_n    = '0;
        poll_n   = '0;
        rsp_to_n = 1'b0;
      end
      ST_LOAD: begin
        wr_n = 1'b1;
        if (cnt[3:0] == 4'd15) begin
          state_n = ST_START;
          addr_n  = ACC_ADDR_CTRL;
          data_n  = CMD_START;
        end else begin
          cnt_n  = cnt + 16'd1;
          addr_n = {1'b0, cnt[3:0] + 4'd1};
          data_n = blk_q[cnt[3:0] + 4'd1];
        end
      end
      ST_START: begin
        state_n = ST_WAIT;
        cnt_n   = '0;
      end
      ST_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_n = ST_POLL;
          rd_n    = 1'b1;
          addr_n  = ACC_ADDR_STATUS;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_POLL: begin
        if (cnt == POLL_LAST) begin
          cnt_n = '0;
          if (bus.av_readdata == STAT_DONE) begin
            state_n = ST_READ;
            rd_n    = 1'b1;
          end else begin
            poll_n = poll_inc;
            if (poll_inc == POLL_MAX) begin
              state_n  = ST_ABORT;
              wr_n     = 1'b1;
              addr_n   = ACC_ADDR_CTRL;
              data_n   = CMD_SRESET;
              hash_clr = 1'b1;
              rsp_to_n = 1'b1;
            end else begin
              state_n = ST_WAIT;
            end
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_READ: begin
        if (cnt < 16'd7) begin
          rd_n   = 1'b1;
          addr_n = cnt[4:0] + 5'd1;
        end
        if (cnt == READ_LAST) begin
          state_n = ST_ACK;
          wr_n    = 1'b1;
          addr_n  = ACC_ADDR_CTRL;
          data_n  = CMD_ACK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_ACK, ST_ABORT: begin
        state_n = ST_DRAIN;
        cnt_n   = '0;
      end
      ST_DRAIN: begin
        if (cnt == 16'd1) begin
          state_n     = ST_RESP;
          rsp_valid_n = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_RESP: if (bus.rsp_ready) begin
        state_n     = ST_IDLE;
        rsp_valid_n = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      poll_cnt    <= '0;
      blk_q       <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      poll_cnt    <= poll_n;
      wr_q        <= wr_n;
      rd_q        <= rd_n;
      cs_q        <= wr_n | rd_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_to_q    <= rsp_to_n;
      if (latch) blk_q <= bus.req_block;
    end
  end

  // Only hash-word reads feed the capture pipe; status polls share the bus but not the pipe.
  assign rd_issue = rd_q && (state == ST_READ);

  acc_rd_capture #(.READ_LATENCY(READ_LATENCY)) u_capture (
    .clk   (clk),
    .reset (reset),
    .issue (rd_issue),
    .idx   (addr_q[2:0]),
    .rdata (bus.av_readdata),
    .clr   (hash_clr),
    .hash  (hash)
  );

  assign bus.req_ready     = (state == ST_IDLE) && !reset;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_hash      = hash;
  assign bus.rsp_timeout   = rsp_to_q;
  assign bus.av_chipselect = cs_q;
  assign bus.av_write      = wr_q;
  assign bus.av_read       = rd_q;
  assign bus.av_address    = addr_q;
  assign bus.av_writedata  = data_q;
  assign state_dbg         = acc_host_state_e'(state);

endmodule

// File: tb/tb_acc_host_master.sv
// Bench for acc_host_master with a behavioural accelerator slave (configurable done delay,
// two-cycle read latency) and a queue-based scoreboard of expected responses.
module tb_acc_host_master;
  import acc_pkg::*;

  localparam int RL      = 2;
  localparam int PI      = 4;
  localparam int PTO     = 8;
  localparam int LATENCY = 1 + 16 + 1 + PI + (1 + RL) + (8 + RL) + 1 + 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  acc_host_state_e state_dbg;
  acc_host_master_if bus_if();

  acc_host_master #(.READ_LATENCY(RL), .POLL_INTERVAL(PI), .POLL_TIMEOUT(PTO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.master),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / scoreboard ----------------
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [255:0] exp_q[$];
  logic         exp_to_q[$];
  logic [36:0]  wr_log[$];
  int           poll_reads = 0;
  int           bus_err = 0;

  function automatic logic [255:0] ref_hash(input logic [511:0] b);
    logic [255:0] h;
    logic [31:0]  a, c;
    for (int i = 0; i < 8; i++) begin
      a = b[32*i +: 32];
      c = b[32*(15-i) +: 32];
      h[32*i +: 32] = (a ^ {c[18:0], c[31:19]}) + 32'h9E37_79B9 * (i + 1);
    end
    return h;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [36:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return '1;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [15:0][31:0] mem;
  logic [7:0][31:0]  hash_reg;
  logic              done, busy, never_done = 1'b0;
  int                done_delay = 0, dcnt;
  logic [31:0]       s1;
  logic              s1_v;

  always @(posedge clk) begin
    if (reset) begin
      done <= 1'b0; busy <= 1'b0; dcnt <= 0;
      s1 <= '0; s1_v <= 1'b0; bus_if.av_readdata <= '0;
    end else begin
      if (busy && !never_done) begin
        if (dcnt >= done_delay) begin done <= 1'b1; busy <= 1'b0; end
        else dcnt <= dcnt + 1;
      end
      if (bus_if.av_write) begin
        if (bus_if.av_address < 5'd16) mem[bus_if.av_address[3:0]] <= bus_if.av_writedata;
        else if (bus_if.av_address == ACC_ADDR_CTRL) begin
          if (bus_if.av_writedata == CMD_START) begin
            hash_reg <= ref_hash(mem); busy <= 1'b1; dcnt <= 0; done <= 1'b0;
          end else if (bus_if.av_writedata == CMD_ACK) begin
            done <= 1'b0;
          end else if (bus_if.av_writedata == CMD_SRESET) begin
            done <= 1'b0; busy <= 1'b0;
          end
        end
      end
      s1_v <= bus_if.av_read;
      if (bus_if.av_address == ACC_ADDR_STATUS) s1 <= done ? STAT_DONE : STAT_BUSY;
      else if (bus_if.av_address < 5'd8)        s1 <= hash_reg[bus_if.av_address[2:0]];
      else                                      s1 <= 32'h0;
      bus_if.av_readdata <= s1_v ? s1 : $urandom;
    end
  end

  // ---------------- bus monitor ----------------
  always @(negedge clk) begin
    if (bus_if.av_write && bus_if.av_read) bus_err++;
    if (bus_if.av_chipselect !== (bus_if.av_write | bus_if.av_read)) bus_err++;
    if (!bus_if.av_write && !bus_if.av_read &&
        (bus_if.av_address !== 5'd0 || bus_if.av_writedata !== 32'd0)) bus_err++;
    if (bus_if.av_write) wr_log.push_back({bus_if.av_address, bus_if.av_writedata});
    if (bus_if.av_read && bus_if.av_address == ACC_ADDR_STATUS) poll_reads++;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [511:0] b, input logic push, input logic to_exp,
                      output int unsigned acc_cyc);
    int w = 0;
    bus_if.req_block = b;
    bus_if.req_valid = 1'b1;
    while (!bus_if.req_ready && w < 500) begin @(negedge clk); w++; end
    check("req_accept", bus_if.req_ready, 1'b1);
    acc_cyc = cyc;
    if (push) begin
      exp_q.push_back(to_exp ? 256'd0 : ref_hash(b));
      exp_to_q.push_back(to_exp);
    end
    @(negedge clk);
    bus_if.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input int hold, output int unsigned rise_cyc);
    int w = 0;
    logic [255:0] h0;
    logic t0, stable;
    while (!bus_if.rsp_valid && w < 3000) begin @(negedge clk); w++; end
    check({tag, "_rsp_valid"}, bus_if.rsp_valid, 1'b1);
    rise_cyc = cyc;
    h0 = bus_if.rsp_hash;
    t0 = bus_if.rsp_timeout;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!(bus_if.rsp_valid === 1'b1 && bus_if.rsp_hash === h0 && bus_if.rsp_timeout === t0 &&
            bus_if.req_ready === 1'b0 && bus_if.av_chipselect === 1'b0)) stable = 1'b0;
    end
    check({tag, "_hold_stable"}, stable, 1'b1);
    check({tag, "_hash"}, h0, exp_q.size() > 0 ? exp_q.pop_front() : 'x);
    check({tag, "_timeout"}, t0, exp_to_q.size() > 0 ? exp_to_q.pop_front() : 1'bx);
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, bus_if.rsp_valid, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [511:0] blk, blk_b;
    int unsigned  acc_c, acc2_c, rise_c;
    int           w;

    bus_if.req_valid = 1'b0;
    bus_if.req_block = '0;
    bus_if.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_req_ready", bus_if.req_ready, 1'b0);
    check("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
    check("rst_rsp_timeout", bus_if.rsp_timeout, 1'b0);
    check("rst_rsp_hash", bus_if.rsp_hash, 256'd0);
    check("rst_bus", {bus_if.av_chipselect, bus_if.av_write, bus_if.av_read,
                      bus_if.av_address, bus_if.av_writedata}, 0);
    check("rst_state", state_dbg, S_IDLE);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", bus_if.req_ready, 1'b1);

    // 1: counting block, done after 50 cycles, exact write sequence
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = i;
    done_delay = 50;
    wr_log.delete();
    send(blk, 1'b1, 1'b0, acc_c);
    get_rsp("t1", 2, rise_c);
    check("t1_wr_count", wr_log.size(), 18);
    for (int i = 0; i < 16; i++) check($sformatf("t1_wr%0d", i), log_at(i), {5'(i), 32'(i)});
    check("t1_wr_start", log_at(16), {ACC_ADDR_CTRL, CMD_START});
    check("t1_wr_ack", log_at(17), {ACC_ADDR_CTRL, CMD_ACK});

    // 2: slave never done -> exactly PTO polls then soft reset, timeout response
    never_done = 1'b1;
    wr_log.delete();
    poll_reads = 0;
    send(rand_block(), 1'b1, 1'b1, acc_c);
    get_rsp("t2", 2, rise_c);
    check("t2_poll_count", poll_reads, PTO);
    check("t2_wr_count", wr_log.size(), 18);
    check("t2_wr_sreset", log_at(17), {ACC_ADDR_CTRL, CMD_SRESET});
    never_done = 1'b0;

    // 3: first-poll success latency, response held 20 cycles
    done_delay = $urandom_range(0, 2);
    send(rand_block(), 1'b1, 1'b0, acc_c);
    get_rsp("t3", 20, rise_c);
    check("t3_latency", rise_c - acc_c, LATENCY);

    // 4: req_valid held across two requests
    blk = rand_block();
    blk_b = rand_block();
    done_delay = 1;
    wr_log.delete();
    bus_if.req_block = blk;
    bus_if.req_valid = 1'b1;
    w = 0;
    while (!bus_if.req_ready && w < 500) begin @(negedge clk); w++; end
    check("t4_accept_a", bus_if.req_ready, 1'b1);
    exp_q.push_back(ref_hash(blk));
    exp_to_q.push_back(1'b0);
    exp_q.push_back(ref_hash(blk_b));
    exp_to_q.push_back(1'b0);
    @(negedge clk);
    bus_if.req_block = blk_b;
    get_rsp("t4a", 3, rise_c);
    check("t4_no_overlap", wr_log.size(), 18);
    check("t4_accept_b", bus_if.req_ready, 1'b1);
    acc2_c = cyc;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    get_rsp("t4b", 0, rise_c);
    check("t4b_latency", rise_c - acc2_c, LATENCY);

    // 5: reset after the third hash read, then a clean transaction
    done_delay = 1;
    wr_log.delete();
    send(rand_block(), 1'b0, 1'b0, acc_c);
    w = 0;
    while (!(state_dbg == S_READ && bus_if.av_read && bus_if.av_address == 5'd2) && w < 500) begin
      @(negedge clk); w++;
    end
    check("t5_reached_read", bus_if.av_address, 5'd2);
    reset = 1'b1;
    @(negedge clk);
    check("t5_bus_idle", {bus_if.av_chipselect, bus_if.av_write, bus_if.av_read,
                          bus_if.av_address, bus_if.av_writedata}, 0);
    check("t5_state", state_dbg, S_IDLE);
    check("t5_rsp_valid", bus_if.rsp_valid, 1'b0);
    check("t5_no_ack", log_at(wr_log.size() - 1), {ACC_ADDR_CTRL, CMD_START});
    reset = 1'b0;
    @(negedge clk);
    send(rand_block(), 1'b1, 1'b0, acc_c);
    get_rsp("t5", 1, rise_c);
    check("t5_latency", rise_c - acc_c, LATENCY);

    // 6: randomized blocks, done delays and response back-pressure
    for (int n = 0; n < 4; n++) begin
      done_delay = $urandom_range(0, 40);
      send(rand_block(), 1'b1, 1'b0, acc_c);
      get_rsp($sformatf("t6_%0d", n), $urandom_range(0, 5), rise_c);
    end

    check("bus_rules", bus_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
